asic_freq: RTL and testbench
============================

ASIC_FREQ -- requirements
Module: asic_freq

Interface
REQ-001 clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 addr  input  4  register select for writes (word index).
REQ-004 value  input  32  write data.
REQ-005 strobe  input  1  one-cycle write enable; writes value to register addr.
REQ-006 samplee  input  1  asynchronous signal under test.
REQ-007 o  output  32  periodic edge count, result of last completed gate period.
REQ-008 oc  output  32  continuous free-running edge count.
REQ-009 tx  output  1  UART transmit line, 8N1, idle high.
REQ-010 col_drvs  output  9  one-hot, active-high digit column drivers; bit n = digit n.
REQ-011 seg_drvs  output  8  active-high segments: [0]=a … [6]=g, [7]=decimal point.

Function
REQ-012 Register map, written on the clk edge where strobe=1:
- addr 0: UART divider = value[15:0]; values below 4 are stored as 4.
- addr 1: gate period = value[31:0], in clk cycles.
- addr 2: display mode = value[0].
- addr 3: digits 7..0, 4 bits each, digit0 = value[3:0].
- addr 4: digit 8 = value[3:0].
- addr 5: decimal points 8..0 = value[8:0].
- addr 6–15: writes ignored, no state change.
REQ-013 samplee passes through a 2-flop synchronizer; a rising edge is synchronized sample 1 with previous synchronized sample 0.
REQ-014 oc increments by 1 per detected rising edge and wraps 0xFFFFFFFF -> 0.
REQ-015 Gate logic:
- A gate counter counts edges and a timer counts clk cycles 0..period-1.
- In the cycle the timer equals period-1: o <= gate count + (edge this cycle ? 1 : 0); gate count and timer reset to 0.
REQ-016 Period 0 disables gating: timer and gate count hold at 0, o holds its value.
REQ-017 A write to addr 1 restarts the timer and gate count at 0 on the next cycle; o is unchanged.
REQ-018 UART frame contents: each o update starts a frame of 8 uppercase ASCII hex characters of o (MSB nibble first), then CR (0x0D), then LF (0x0A).
REQ-019 UART bit timing: each byte is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts exactly divider clk cycles.
REQ-020 UART value latching:
- The o value is latched at frame start.
- An o update arriving while a frame is in progress is dropped.
- Frames are sent back-to-back with no extra idle gap.
REQ-021 A divider write during a frame takes effect at the next bit boundary.
REQ-022 Display source:
- Mode 0: digits 7..0 = hex nibbles of o (digit0 = o[3:0]); digit 8 blank (all segments off except its decimal point).
- Mode 1: digits come from registers addr 3/4.
REQ-023 Display multiplex: a free-running 10-bit prescaler advances the active digit every 1024 clk cycles, sequence 0,1,…,8,0.
REQ-024 Segment drive: col_drvs is one-hot on the active digit; seg_drvs[6:0] = standard hex 7-seg decode of that digit; seg_drvs[7] = its decimal-point bit (both modes).
REQ-025 Hex decode, segments gfedcba:
- 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
- 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001

Reset
REQ-026 While rst_n=0, all of the following hold asynchronously:
- o=0, oc=0, gate count=0, timer=0, synchronizer flops=0.
- divider=868, period=1000000, mode=0, digit registers=0, decimal points=0.
- UART idle with tx=1.
- prescaler=0, active digit=0, col_drvs=9'h001.
REQ-027 Normal operation resumes on the first clk edge after rst_n rises; a reset mid-frame aborts the frame with tx=1 immediately.

Verification
REQ-028 period=100; samplee toggled with period 10 clk cycles for 300 cycles -> o=10 after each gate; oc increments every 10 cycles.
REQ-029 period=0 -> o holds its prior value while oc keeps counting edges.
REQ-030 divider=2 written -> reads back as 4 (each bit 4 cycles); o=0x1234ABCD -> tx emits bytes "1234ABCD\r\n".
REQ-031 mode=1, addr3=0x76543210, addr4=8, dp=0x100:
- After 1024·k cycles, col_drvs=1<<(k mod 9).
- seg_drvs shows digit k mod 9; segment bit 7 set only on digit 8.
REQ-032 mode=0 with o=0 -> digits 0–7 show 0111111; digit 8 is blank.
REQ-033 rst_n asserted mid-frame and mid-gate -> all outputs reach their REQ-026 reset values without a clk edge.

Source files
------------

// File: rtl/asic_freq.sv
// asic_freq: frequency counter for an asynchronous input.
// Provides a gated edge count (o), a free-running edge count (oc), a UART
// hex report of each gated result, and a 9-digit multiplexed 7-segment display.
module asic_freq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  addr,
   input  logic [31:0] value,
   input  logic        strobe,
   input  logic        samplee,
   output logic [31:0] o,
   output logic [31:0] oc,
   output logic        tx,
   output logic [8:0]  col_drvs,
   output logic [7:0]  seg_drvs
);

   typedef enum logic {U_IDLE, U_BIT} ustate_t;

   logic [15:0] div;
   logic [31:0] period;
   logic        mode;
   logic [31:0] digs;
   logic [3:0]  dig8;
   logic [8:0]  dp;

   logic        sync0, sync1, sync_prev;
   logic        rise;
   logic [31:0] gcnt, timer;
   logic        upd;

   ustate_t     ust;
   logic [31:0] shadow;
   logic [3:0]  chr, bpos;
   logic [15:0] bcnt, bdiv;
   logic [31:0] nib_word;
   logic [7:0]  cur_byte;

   logic [9:0]  presc;
   logic [3:0]  digit;
   logic [3:0]  nib;
   logic        blank;

   // standard hex to 7-segment decode, bits gfedcba
   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_seg = 7'b0111111;
         4'h1: hex_seg = 7'b0000110;
         4'h2: hex_seg = 7'b1011011;
         4'h3: hex_seg = 7'b1001111;
         4'h4: hex_seg = 7'b1100110;
         4'h5: hex_seg = 7'b1101101;
         4'h6: hex_seg = 7'b1111101;
         4'h7: hex_seg = 7'b0000111;
         4'h8: hex_seg = 7'b1111111;
         4'h9: hex_seg = 7'b1101111;
         4'hA: hex_seg = 7'b1110111;
         4'hB: hex_seg = 7'b1111100;
         4'hC: hex_seg = 7'b0111001;
         4'hD: hex_seg = 7'b1011110;
         4'hE: hex_seg = 7'b1111001;
         default: hex_seg = 7'b1110001;
      endcase
   endfunction

   // uppercase ASCII hex character for one nibble
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      hex_ascii = (n < 4'd10) ? (8'h30 + {4'b0, n}) : (8'h37 + {4'b0, n});
   endfunction

   // register file; small dividers are clamped so each bit lasts at least 4 cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div    <= 16'd868;
         period <= 32'd1000000;
         mode   <= 1'b0;
         digs   <= '0;
         dig8   <= '0;
         dp     <= '0;
      end else if (strobe) begin
         case (addr)
            4'd0: div    <= (value[15:0] < 16'd4) ? 16'd4 : value[15:0];
            4'd1: period <= value;
            4'd2: mode   <= value[0];
            4'd3: digs   <= value;
            4'd4: dig8   <= value[3:0];
            4'd5: dp     <= value[8:0];
            default: ;
         endcase
      end
   end

   // two-flop synchronizer plus one history flop for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0     <= 1'b0;
         sync1     <= 1'b0;
         sync_prev <= 1'b0;
      end else begin
         sync0     <= samplee;
         sync1     <= sync0;
         sync_prev <= sync1;
      end
   end

   assign rise = sync1 & ~sync_prev;

   // free-running edge count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) oc <= '0;
      else if (rise) oc <= oc + 32'd1;
   end

   // gate timer: publish the edge count each period; a period write restarts the gate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o     <= '0;
         gcnt  <= '0;
         timer <= '0;
         upd   <= 1'b0;
      end else begin
         upd <= 1'b0;
         if (strobe && addr == 4'd1) begin
            gcnt  <= '0;
            timer <= '0;
         end else if (period == 32'd0) begin
            gcnt  <= '0;
            timer <= '0;
         end else if (timer == period - 32'd1) begin
            o     <= gcnt + {31'b0, rise};
            gcnt  <= '0;
            timer <= '0;
            upd   <= 1'b1;
         end else begin
            gcnt  <= gcnt + {31'b0, rise};
            timer <= timer + 32'd1;
         end
      end
   end

   // byte currently being shifted: 8 hex characters of the latched value, then CR, LF
   always_comb begin
      nib_word = shadow << {chr[2:0], 2'b00};
      cur_byte = hex_ascii(nib_word[31:28]);
      if (chr == 4'd8) cur_byte = 8'h0D;
      else if (chr == 4'd9) cur_byte = 8'h0A;
   end

   // UART frame engine; divider is re-sampled at every bit boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ust    <= U_IDLE;
         tx     <= 1'b1;
         shadow <= '0;
         chr    <= '0;
         bpos   <= '0;
         bcnt   <= '0;
         bdiv   <= 16'd868;
      end else begin
         case (ust)
            U_IDLE: begin
               tx <= 1'b1;
               if (upd) begin
                  shadow <= o;
                  chr    <= '0;
                  bpos   <= '0;
                  bcnt   <= '0;
                  bdiv   <= div;
                  tx     <= 1'b0;
                  ust    <= U_BIT;
               end
            end
            default: begin
               if (bcnt == bdiv - 16'd1) begin
                  bcnt <= '0;
                  bdiv <= div;
                  if (bpos == 4'd9) begin
                     if (chr == 4'd9) begin
                        tx  <= 1'b1;
                        ust <= U_IDLE;
                     end else begin
                        chr  <= chr + 4'd1;
                        bpos <= '0;
                        tx   <= 1'b0;
                     end
                  end else begin
                     bpos <= bpos + 4'd1;
                     tx   <= (bpos == 4'd8) ? 1'b1 : cur_byte[bpos[2:0]];
                  end
               end else begin
                  bcnt <= bcnt + 16'd1;
               end
            end
         endcase
      end
   end

   // display multiplex: advance digit 0..8 every 1024 clocks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         digit <= '0;
      end else begin
         presc <= presc + 10'd1;
         if (presc == 10'd1023) digit <= (digit == 4'd8) ? 4'd0 : digit + 4'd1;
      end
   end

   // digit source select and segment decode; digit 8 is blank in mode 0
   always_comb begin
      nib   = '0;
      blank = 1'b0;
      if (digit == 4'd8) begin
         nib   = dig8;
         blank = ~mode;
      end else if (mode) begin
         nib = digs[{digit[2:0], 2'b00} +: 4];
      end else begin
         nib = o[{digit[2:0], 2'b00} +: 4];
      end
      seg_drvs = {dp[digit], blank ? 7'b0 : hex_seg(nib)};
   end

   assign col_drvs = 9'd1 << digit;

endmodule

// File: tb/tb_asic_freq.sv
// Self-checking bench for asic_freq: event-level reference model, UART receiver,
// randomized input activity and register writes.
module tb_asic_freq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  addr = '0;
   logic [31:0] value = '0;
   logic        strobe = 1'b0;
   logic        samplee = 1'b0;
   logic [31:0] o, oc;
   logic        tx;
   logic [8:0]  col_drvs;
   logic [7:0]  seg_drvs;

   asic_freq dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .value(value), .strobe(strobe),
      .samplee(samplee), .o(o), .oc(oc), .tx(tx), .col_drvs(col_drvs),
      .seg_drvs(seg_drvs)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // ---------------- reference model ----------------
   int          cyc;
   bit          h1, h2, h3;
   logic [31:0] m_oc, mo, m_base, m_per, m_digs;
   longint      m_end, m_free;
   int          m_div;
   bit          m_mode;
   logic [3:0]  m_dig8;
   logic [8:0]  m_dp;
   logic [31:0] exp_q [$];

   task automatic m_reset();
      cyc = 0; h1 = 0; h2 = 0; h3 = 0;
      m_oc = 0; mo = 0; m_base = 0; m_per = 32'd1000000; m_end = 1000000;
      m_free = 0; m_div = 868; m_mode = 0; m_digs = 0; m_dig8 = 0; m_dp = 0;
      exp_q.delete();
   endtask

   task automatic m_step();
      bit det;
      bit gate_done;
      cyc++;
      // an input level reaches the detector two clocks after it is sampled
      det = h2 && !h3;
      h3 = h2; h2 = h1; h1 = samplee;
      m_oc = m_oc + det;
      gate_done = 0;
      if (strobe) begin
         case (addr)
            4'd0: m_div = (value[15:0] < 4) ? 4 : int'(value[15:0]);
            4'd2: m_mode = value[0];
            4'd3: m_digs = value;
            4'd4: m_dig8 = value[3:0];
            4'd5: m_dp = value[8:0];
            default: ;
         endcase
      end
      if (strobe && addr == 4'd1) begin
         m_per = value; m_base = m_oc; m_end = cyc + longint'(value);
      end else if (m_per != 0 && cyc == m_end) begin
         mo = m_oc - m_base; m_base = m_oc; m_end = cyc + longint'(m_per);
         gate_done = 1;
      end
      if (gate_done && cyc >= m_free) begin
         exp_q.push_back(mo);
         m_free = cyc + 1 + 100 * m_div;
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else m_step();
      end
   end

   function automatic logic [7:0] exp_seg(int d);
      logic [3:0] n;
      bit bl;
      bl = 0;
      if (d == 8) begin n = m_dig8; bl = !m_mode; end
      else if (m_mode) n = m_digs[4*d +: 4];
      else n = mo[4*d +: 4];
      return {m_dp[d], bl ? 7'h00 : seg_tab[n]};
   endfunction

   function automatic logic [7:0] exp_char(logic [31:0] w, int idx);
      int nibv;
      if (idx == 8) return 8'h0D;
      if (idx == 9) return 8'h0A;
      nibv = int'((w >> (4 * (7 - idx))) & 32'hF);
      return (nibv < 10) ? 8'(48 + nibv) : 8'(65 + nibv - 10);
   endfunction

   // ---------------- per-cycle output monitor ----------------
   bit mon_en = 0;
   always @(negedge clk) begin
      int d;
      logic [8:0] one9;
      if (mon_en && rst_n) begin
         d = (cyc / 1024) % 9;
         one9 = 9'd1;
         check_eq("o", o, mo);
         check_eq("oc", oc, m_oc);
         check_eq("col_drvs", col_drvs, one9 << d);
         check_eq("seg_drvs", seg_drvs, exp_seg(d));
      end
   end

   // ---------------- UART receiver ----------------
   bit          rx_en = 0;
   int          rx_idx = 0;
   int          rx_frames = 0;
   logic [31:0] rx_word = '0;
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (rx_en && rst_n && tx === 1'b0) begin
            repeat (m_div / 2) @(negedge clk);
            if (rx_en) check_eq("uart_start", tx, 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (m_div) @(negedge clk);
               b[i] = tx;
            end
            repeat (m_div) @(negedge clk);
            if (rx_en) begin
               check_eq("uart_stop", tx, 1'b1);
               if (rx_idx == 0) begin
                  check_eq("uart_frame_queued", exp_q.size() != 0, 1'b1);
                  rx_word = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
               end
               check_eq("uart_byte", b, exp_char(rx_word, rx_idx));
               if (rx_idx == 9) begin rx_idx = 0; rx_frames++; end
               else rx_idx++;
            end
         end
      end
   end

   // ---------------- input activity ----------------
   int smode = 0;
   int tcnt = 0;
   initial forever begin
      @(posedge clk); #1;
      case (smode)
         1: begin tcnt++; if (tcnt == 5) begin tcnt = 0; samplee = ~samplee; end end
         2: if ($urandom_range(0, 2) == 0) samplee = ~samplee;
         default: ;
      endcase
   end

   task automatic wr(input logic [3:0] a, input logic [31:0] v);
      @(posedge clk); #1;
      addr = a; value = v; strobe = 1'b1;
      @(posedge clk); #1;
      strobe = 1'b0;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_o"}, o, 32'd0);
      check_eq({pfx, "_oc"}, oc, 32'd0);
      check_eq({pfx, "_tx"}, tx, 1'b1);
      check_eq({pfx, "_col"}, col_drvs, 9'h001);
      check_eq({pfx, "_seg"}, seg_drvs, 8'h3F);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] snap;
      bit seen;
      #23;
      check_reset_outputs("rst_init");
      #4 rst_n = 1'b1;
      mon_en = 1; rx_en = 1;

      wr(4'd0, 32'd2);
      smode = 1;
      wr(4'd1, 32'd100);
      @(negedge clk); snap = oc;
      repeat (300) @(negedge clk);
      check_eq("oc_30_edges", oc - snap, 32'd30);
      repeat (20) @(negedge clk);
      check_eq("o_gate_10", o, 32'd10);

      smode = 2;
      for (int s = 0; s < 6; s++) begin
         wr(4'd1, $urandom_range(20, 200));
         wr(4'($urandom_range(6, 15)), $urandom);
         wr(4'd3, $urandom);
         repeat ($urandom_range(300, 800)) @(posedge clk);
      end

      wr(4'd1, 32'd0);
      @(negedge clk); snap = o;
      repeat (400) @(negedge clk);
      check_eq("o_hold_period0", o, snap);

      smode = 0;
      wr(4'd3, 32'h76543210);
      wr(4'd4, 32'd8);
      wr(4'd5, 32'h100);
      wr(4'd2, 32'd1);
      repeat (9300) @(posedge clk);

      wr(4'd2, 32'd0);
      smode = 2;
      wr(4'd1, 32'd37);
      repeat (9300) @(posedge clk);

      smode = 0;
      wr(4'd1, 32'd0);
      repeat (1000) @(negedge clk);
      check_eq("uart_drain_queue", exp_q.size(), 0);
      check_eq("uart_drain_idx", rx_idx, 0);
      check_eq("uart_frames_seen", rx_frames > 3, 1'b1);

      rx_en = 0;
      smode = 1;
      wr(4'd1, 32'd50);
      seen = 0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (tx === 1'b0) seen = 1;
      end
      check_eq("frame_start_seen", seen, 1'b1);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_reset_outputs("rst_mid");
      #3 rst_n = 1'b1;
      smode = 0;
      repeat (9300) @(posedge clk);
      @(negedge clk);
      check_eq("o_after_reset", o, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
